// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared encodings, defaults and helpers for the data memory controller
package dmem_ctrl_pkg;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int DEPTH_DEFAULT = 4096;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'd0, SPLIT = 2'd1, RESP = 2'd2} state_t;
  function automatic logic [3:0] size_mask(input logic [1:0] s);
    return s == SIZE_B ? 4'b0001 : s == SIZE_H ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic [31:0] load_ext(input logic [31:0] v, input logic [1:0] s, input logic u);
    return s == SIZE_B ? {{24{~u & v[7]}}, v[7:0]} : s == SIZE_H ? {{16{~u & v[15]}}, v[15:0]} : v;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port byte-enabled 32-bit RAM with combinational read of the current index
module dmem_ram #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // byte-lane writes; contents survive reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed load/store controller; DMEM_MISALIGN_SPLIT_EN enables two-beat misaligned access
module dmem_ctrl import dmem_ctrl_pkg::*; #(
  parameter int DEPTH_WORDS = DEPTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        req_ready_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state;
  logic rvalid_q, err_q, accept, misal, err, split, we_q, uns_q, ld_uns;
  logic [31:0] rdata_q, lo_q, wdata_hi_q, ram_rdata, ram_wdata, ld_sh, ld;
  logic [33:0] last;
  logic [AW-1:0] idx, idx_q, ram_idx;
  logic [7:0] be64;
  logic [63:0] wd64;
  logic [3:0] be_hi_q, ram_be;
  logic [1:0] lane_q, size_q, ld_lane, ld_size;
  assign req_ready_o = state == IDLE && rst != RST_ENABLE;
  assign accept = req_i && req_ready_o;
  assign last = {2'b0, addr_i} - {2'b0, BASE_ADDR} + (size_i == SIZE_B ? 34'd0 : size_i == SIZE_H ? 34'd1 : 34'd3);
  assign misal = size_i == SIZE_H ? addr_i[0] : size_i == SIZE_W && addr_i[1:0] != 2'b00;
`ifdef DMEM_MISALIGN_SPLIT_EN
  assign split = misal;
`else
  assign split = 1'b0;
`endif
  assign err = size_i == 2'b11 || addr_i < BASE_ADDR || last >= 34'(4 * DEPTH_WORDS) || (misal && !split);
  assign idx = AW'((addr_i - BASE_ADDR) >> 2);
  // a misaligned access spans two words: low half of the shifted lanes hits idx, high half idx+1
  assign be64 = {4'b0000, size_mask(size_i)} << addr_i[1:0];
  assign wd64 = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
  assign ram_idx = state == SPLIT ? idx_q + AW'(1) : idx;
  assign ram_be = accept && we_i && !err ? be64[3:0] : state == SPLIT && we_q && rst != RST_ENABLE ? be_hi_q : 4'b0000;
  assign ram_wdata = state == SPLIT ? wdata_hi_q : wd64[31:0];
  assign ld_lane = state == SPLIT ? lane_q : addr_i[1:0];
  assign ld_size = state == SPLIT ? size_q : size_i;
  assign ld_uns = state == SPLIT ? uns_q : unsigned_i;
  assign ld_sh = 32'((state == SPLIT ? {ram_rdata, lo_q} : {32'b0, ram_rdata}) >> {ld_lane, 3'b000});
  assign ld = load_ext(ld_sh, ld_size, ld_uns);
  dmem_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk(clk), .idx(ram_idx), .be(ram_be), .wdata(ram_wdata), .rdata(ram_rdata)
  );
  // access state and registered response
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= IDLE;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= ZERO_WORD;
    end else begin
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= ZERO_WORD;
      if (accept) begin
        state <= split && !err ? SPLIT : RESP;
        if (!(split && !err)) begin
          rvalid_q <= 1'b1;
          err_q <= err;
          rdata_q <= err || we_i ? ZERO_WORD : ld;
        end
      end else if (state == SPLIT) begin
        state <= RESP;
        rvalid_q <= 1'b1;
        rdata_q <= we_q ? ZERO_WORD : ld;
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
  end
  // request context kept for the second beat
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= idx;
      be_hi_q <= be64[7:4];
      wdata_hi_q <= wd64[63:32];
      lo_q <= ram_rdata;
      lane_q <= addr_i[1:0];
      size_q <= size_i;
      we_q <= we_i;
      uns_q <= unsigned_i;
    end
  end
  assign rvalid_o = rvalid_q && rst != RST_ENABLE;
  assign err_o = err_q && rst != RST_ENABLE;
  assign rdata_o = rst == RST_ENABLE ? ZERO_WORD : rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl against a byte-array reference model
module tb_dmem_ctrl;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int NBYTES = 4 * 4096;
  logic clk = 1'b0, rst = 1'b1, req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic [1:0] size_i = 2'b00;
  logic req_ready_o, rvalid_o, err_o;
  logic [31:0] rdata_o, got;
  logic [7:0] mm [NBYTES];
  int compared = 0, mismatched = 0;

  dmem_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_ready_o(req_ready_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input bit u,
                                output bit e, output logic [31:0] rd, output int lat);
    int n;
    bit mis;
    longint lastb;
    logic [31:0] v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
    lastb = longint'(a) + n - 1;
    mis = (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    e = sz == 2'd3 || lastb >= NBYTES || (mis && !SPLIT_EN);
    lat = (mis && !e) ? 2 : 1;
    rd = 32'h0;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < n; k++) mm[int'(a) + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mm[int'(a) + k];
        if (!u && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        rd = v;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input bit u, input string tag, output logic [31:0] res);
    bit e;
    logic [31:0] rd;
    int lat, cyc, w;
    model(we, a, wd, sz, u, e, rd, lat);
    w = 0;
    @(negedge clk);
    while (req_ready_o !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; size_i = sz; unsigned_i = u;
    @(posedge clk);
    #1 req_i = 1'b0;
    cyc = 1;
    while (rvalid_o !== 1'b1 && cyc < 6) begin
      @(posedge clk);
      #1 cyc++;
    end
    res = rdata_o;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_err"}, {31'b0, err_o}, {31'b0, e});
    chk({tag, "_rdata"}, rdata_o, rd);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, {31'b0, rvalid_o}, 32'd0);
  endtask

  initial begin
    int acc, val;
    logic [31:0] a, base;
    // reset state, with a request pending that must not be accepted
    req_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready_o}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    @(negedge clk);
    req_i = 1'b0;
    rst = 1'b0;
    // word store/load
    txn(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, "sw10", got);
    txn(0, 32'h10, 32'h0, 2'b10, 0, "lw10", got);
    chk("lw10_const", got, 32'hDEADBEEF);
    // byte store with sign/zero extension
    txn(1, 32'h13, 32'h00000080, 2'b00, 0, "sb13", got);
    txn(0, 32'h13, 32'h0, 2'b00, 0, "lb13", got);
    chk("lb13_const", got, 32'hFFFFFF80);
    txn(0, 32'h13, 32'h0, 2'b00, 1, "lbu13", got);
    chk("lbu13_const", got, 32'h00000080);
    txn(0, 32'h10, 32'h0, 2'b10, 0, "lw10b", got);
    chk("lw10b_const", got, 32'h80ADBEEF);
    // misaligned half
    txn(0, 32'h11, 32'h0, 2'b01, 0, "lh11", got);
    chk("lh11_const", got, SPLIT_EN ? 32'hFFFFADBE : 32'h0);
    // out of range and illegal size
    txn(1, 32'h3FFC, 32'hCAFEF00D, 2'b10, 0, "sw3ffc", got);
    txn(1, 32'h4000, 32'h12345678, 2'b10, 0, "sw4000", got);
    txn(1, 32'h3FFE, 32'h12345678, 2'b10, 0, "sw3ffe", got);
    txn(0, 32'h3FFC, 32'h0, 2'b10, 0, "lw3ffc", got);
    chk("lw3ffc_const", got, 32'hCAFEF00D);
    txn(1, 32'h10, 32'h0, 2'b11, 0, "ssz11", got);
    txn(0, 32'h10, 32'h0, 2'b11, 0, "lsz11", got);
    txn(0, 32'h10, 32'h0, 2'b10, 0, "lw10c", got);
    chk("lw10c_const", got, 32'h80ADBEEF);
    // known contents for both test windows
    for (int i = 0; i < 20; i++) txn(1, 32'(4 * i), $urandom, 2'b10, 0, "init_lo", got);
    txn(1, 32'h10, 32'h80ADBEEF, 2'b10, 0, "init_10", got);
    for (int i = 0; i < 16; i++) txn(1, 32'h3FC0 + 32'(4 * i), $urandom, 2'b10, 0, "init_hi", got);
    // reset during the second beat of a split store
    if (SPLIT_EN) begin
      mm[14] = 8'h44;
      mm[15] = 8'h33;
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0E; wdata_i = 32'h11223344; size_i = 2'b10;
      @(posedge clk);
      #1 req_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_rvalid", {31'b0, rvalid_o}, 32'd0);
      chk("abort_ready", {31'b0, req_ready_o}, 32'd0);
      rst = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1 chk("abort_quiet", {31'b0, rvalid_o}, 32'd0);
      end
      txn(0, 32'h10, 32'h0, 2'b10, 0, "abort_w10", got);
      chk("abort_w10_const", got, 32'h80ADBEEF);
      txn(0, 32'h0E, 32'h0, 2'b00, 1, "abort_b0e", got);
      chk("abort_b0e_const", got, 32'h44);
      txn(0, 32'h0F, 32'h0, 2'b00, 1, "abort_b0f", got);
      chk("abort_b0f_const", got, 32'h33);
    end
    // randomized traffic near both ends of the array
    for (int i = 0; i < 80; i++) begin
      base = $urandom_range(0, 1) ? 32'h3FC0 : 32'h0;
      a = base + $urandom_range(0, 67);
      txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd", got);
    end
    // continuous request: one accept every second cycle
    txn(1, 32'h20, 32'h5A5AA5A5, 2'b10, 0, "sw20", got);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20; size_i = 2'b10; unsigned_i = 1'b0;
    acc = 0;
    val = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o === 1'b1) acc++;
      if (rvalid_o === 1'b1) begin
        val++;
        chk("hold_rdata", rdata_o, 32'h5A5AA5A5);
      end
      @(negedge clk);
    end
    req_i = 1'b0;
    chk("hold_accepts", acc, 10);
    chk("hold_resps", val, 10);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words in the data array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high (asserted when rst == `RstEnable).
REQ-005 SHALL have ports req_i input 1 request valid; req_ready_o output 1 controller can accept.
REQ-006 SHALL have ports we_i input 1 store(1)/load(0); addr_i input 32 byte address; wdata_i input 32 store data (LSB-aligned).
REQ-007 SHALL have ports size_i input 2 (00 byte, 01 half, 10 word, 11 illegal); unsigned_i input 1 zero-extend loads.
REQ-008 SHALL have ports rvalid_o output 1 response pulse; rdata_o output 32 load result; err_o output 1 error, valid with rvalid_o.

Function
REQ-009 SHALL implement states IDLE, SPLIT, RESP; req_ready_o = 1 only in IDLE.
REQ-010 SHALL accept a request on a cycle where req_i && req_ready_o; inputs not sampled otherwise.
REQ-011 Aligned access (byte any, half addr[0]=0, word addr[1:0]=0) SHALL complete in IDLE->RESP; rvalid_o high exactly one cycle after acceptance, for loads and stores.
REQ-012 Stores SHALL write only addressed bytes (byte-enable from size_i, addr[1:0]) at the accepting edge; other bytes unchanged.
REQ-013 Loads SHALL right-align selected bytes; sign-extend from bit 7/15 when unsigned_i=0, zero-extend when 1; word loads unmodified.
REQ-014 rdata_o SHALL be 32'h0 for stores, errors and whenever rvalid_o=0.
REQ-015 Error (size_i=11, or any addressed byte outside BASE_ADDR..BASE_ADDR+4*DEPTH_WORDS-1) SHALL cause no write, rvalid_o and err_o high one cycle after acceptance.
REQ-016 RESP SHALL last one cycle then return to IDLE; back-to-back requests accepted every second cycle.
REQ-017 Store followed by load of same address SHALL return the stored data (no stale read).
REQ-018 Array contents SHALL be indexed (addr_i-BASE_ADDR)>>2; no wrap-around beyond DEPTH_WORDS (out-of-range is error).

Reset
REQ-019 While rst asserted: state=IDLE, rvalid_o=0, err_o=0, rdata_o=32'h0, req_ready_o=0.
REQ-020 Reset mid-operation (SPLIT or RESP) SHALL abandon the access: no response emitted; a second-word write not yet performed SHALL NOT occur.
REQ-021 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-022 Macro DMEM_MISALIGN_SPLIT_EN: when defined, misaligned half/word accesses SHALL be performed as two word beats: IDLE (first word, low bytes) -> SPLIT (next word, high bytes) -> RESP; rvalid_o two cycles after acceptance.
REQ-023 In split mode, store bytes in both words SHALL be written, first word at acceptance edge, second word at SPLIT edge; load result assembled from both beats.
REQ-024 When DMEM_MISALIGN_SPLIT_EN undefined, misaligned half/word SHALL be treated as error per REQ-015; SPLIT state absent.

Structure
REQ-025 size encodings (SIZE_B/H/W), state encodings and DEPTH default SHALL live in the shared defines file alongside `RstEnable, `ZeroWord.
REQ-026 SHALL contain one sub-module dmem_ram: single-port, byte-enabled 32-bit synchronous RAM, combinational read of current index.

Verification
REQ-027 Reset then store word 32'hDEADBEEF @0x10, load word @0x10 -> rvalid_o one cycle after each accept, rdata_o=32'hDEADBEEF, err_o=0.
REQ-028 Store byte 8'h80 @0x13, load byte signed @0x13 -> 32'hFFFFFF80; unsigned -> 32'h00000080; load word @0x10 -> 32'h80ADBEEF.
REQ-029 Load half @0x11: split enabled -> rvalid_o two cycles after accept, rdata_o = sign-extended bytes 0x12:0x11; disabled -> err_o=1, rdata_o=0.
REQ-030 Store word @0x0000_4000 (DEPTH 4096) -> err_o=1, no array word modified; size_i=11 -> err_o=1.
REQ-031 Split store word 32'h11223344 @0x0E, assert rst during SPLIT -> no rvalid_o; word @0x10 unchanged, bytes 0x0E/0x0F = 44/33.
REQ-032 Hold req_i high continuously -> req_ready_o toggles, exactly one accept per two cycles (aligned), no request lost or duplicated.
